// File: rtl/serial_pattern_tx_moore.sv
// Moore serial pattern transmitter: latches up to WIDTH bits and shifts them out
// MSB-first on w, holding each bit for BIT_CLKS cycles, with repeat and abort.
module serial_pattern_tx_moore #(
    parameter int WIDTH    = 8,
    parameter int LEN_W    = 4,
    parameter int BIT_CLKS = 50000000
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_en,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             w,
    output logic             busy,
    output logic             bit_strobe,
    output logic             done
);

    localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             w_q, w_d;
    logic             busy_q, busy_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] start_last;

    // Index of the first transmitted bit, with over-long lengths clamped to WIDTH.
    always_comb begin
        if (len > LEN_W'(WIDTH)) begin
            start_last = IDX_W'(WIDTH - 1);
        end else begin
            start_last = IDX_W'(len - LEN_W'(1));
        end
    end

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        last_d   = last_q;
        pat_d    = pat_q;
        w_d      = w_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                w_d    = 1'b1;
                busy_d = 1'b0;
                if (start && len != '0) begin
                    state_d  = SHIFT;
                    pat_d    = pattern;
                    last_d   = start_last;
                    idx_d    = start_last;
                    cnt_d    = '0;
                    w_d      = pattern[start_last];
                    busy_d   = 1'b1;
                    strobe_d = 1'b1;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    w_d     = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        idx_d    = idx_q - IDX_W'(1);
                        w_d      = pat_q[idx_q - IDX_W'(1)];
                        strobe_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (repeat_en) begin
                            idx_d    = last_q;
                            w_d      = pat_q[last_q];
                            strobe_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            w_d     = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                w_d     = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            w_q      <= 1'b1;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
        // NOTE: the latched frame is only read after a start reloads it, so it
        // carries no reset and stays plain data storage.
        pat_q  <= pat_d;
        last_q <= last_d;
    end

    assign w          = w_q;
    assign busy       = busy_q;
    assign bit_strobe = strobe_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx_moore.sv
// Directed bench: each step queues the expected per-cycle {w,busy,bit_strobe,done}
// derived from the frame timing, and every clock pops and compares one entry.
module tb_serial_pattern_tx_moore;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int BC    = 4;

    logic             Clock     = 1'b0;
    logic             Resetn    = 1'b0;
    logic             start     = 1'b0;
    logic             stop      = 1'b0;
    logic             repeat_en = 1'b0;
    logic [WIDTH-1:0] pattern   = '0;
    logic [LEN_W-1:0] len       = '0;
    logic             w, busy, bit_strobe, done;

    serial_pattern_tx_moore #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W),
        .BIT_CLKS(BC)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .stop      (stop),
        .repeat_en (repeat_en),
        .pattern   (pattern),
        .len       (len),
        .w         (w),
        .busy      (busy),
        .bit_strobe(bit_strobe),
        .done      (done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [3:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) push(4'b1000, tag);
    endtask

    // Frame image: bit i is pat[n_bits-1-i] for BC cycles, strobe on its first cycle.
    task automatic push_frame(input logic [7:0] pat, input int n_bits, input bit first_done,
                              input int limit, input string tag);
        int c = 0;
        for (int i = 0; i < n_bits; i++) begin
            for (int j = 0; j < BC; j++) begin
                if (c < limit) push({pat[n_bits-1-i], 1'b1, j == 0, first_done && c == 0}, tag);
                c++;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge Clock);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL underflow: no expected entry queued, got %b", {w, busy, bit_strobe, done});
        end else begin
            e = sb.pop_front();
            assert ({w, busy, bit_strobe, done} === e.v) else begin
                errors++;
                $error("FAIL %s: got w/busy/strobe/done=%b expected %b",
                       e.tag, {w, busy, bit_strobe, done}, e.v);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        Resetn = 1'b0;
        push_idle(2, "reset");
        run(2);
        Resetn = 1'b1;
        push_idle(1, "post_reset");
        run(1);

        // Basic 0011 frame
        pattern = 8'h03; len = 4'd4; start = 1'b1;
        push_frame(8'h03, 4, 1'b0, 16, "basic");
        push(4'b1001, "basic_done");
        push_idle(1, "basic_idle");
        run(1); start = 1'b0; run(17);

        // Repeat mode, input changes after start must not matter
        repeat_en = 1'b1; start = 1'b1;
        push_frame(8'h03, 4, 1'b0, 16, "rep1");
        push_frame(8'h03, 4, 1'b1, 16, "rep2");
        push_frame(8'h03, 4, 1'b1, 16, "rep3");
        push(4'b1001, "rep_done");
        push_idle(1, "rep_idle");
        run(1); start = 1'b0; pattern = 8'hFF; len = 4'd2;
        run(39);
        repeat_en = 1'b0;
        run(10);

        // Abort in the 2nd cycle of bit 2
        pattern = 8'h0A; len = 4'd4; start = 1'b1;
        push_frame(8'h0A, 4, 1'b0, 10, "abort");
        push_idle(2, "abort_idle");
        run(1); start = 1'b0; run(9);
        stop = 1'b1; run(1); stop = 1'b0; run(1);

        // Stop coinciding with frame end and repeat: no done, no restart
        pattern = 8'h01; len = 4'd1; repeat_en = 1'b1; start = 1'b1;
        push_frame(8'h01, 1, 1'b0, 4, "stop_end");
        push_idle(2, "stop_end_idle");
        run(1); start = 1'b0; run(3);
        stop = 1'b1; run(1); stop = 1'b0; repeat_en = 1'b0; run(1);

        // len = 0 ignored
        len = 4'd0; start = 1'b1;
        push_idle(3, "len0");
        run(3); start = 1'b0;

        // len = 15 clamps to 8 bits
        pattern = 8'hC5; len = 4'd15; start = 1'b1;
        push_frame(8'hC5, 8, 1'b0, 32, "len15");
        push(4'b1001, "len15_done");
        push_idle(1, "len15_idle");
        run(1); start = 1'b0; run(33);

        // len = 1, single 0 bit
        pattern = 8'h00; len = 4'd1; start = 1'b1;
        push_frame(8'h00, 1, 1'b0, 4, "len1");
        push(4'b1001, "len1_done");
        push_idle(1, "len1_idle");
        run(1); start = 1'b0; run(5);

        // Reset during bit 1 with start held through it
        pattern = 8'h03; len = 4'd4; start = 1'b1;
        push_frame(8'h03, 4, 1'b0, 6, "rst_mid");
        push_idle(1, "rst_vals");
        push_frame(8'h03, 4, 1'b0, 16, "rst_restart");
        push(4'b1001, "rst_done");
        push_idle(1, "rst_idle");
        run(1); start = 1'b0; run(5);
        Resetn = 1'b0; start = 1'b1; run(1);
        Resetn = 1'b1; run(1);
        start = 1'b0; run(17);

        // Start ignored while busy, then start in the done cycle chains a frame
        pattern = 8'h03; len = 4'd4; start = 1'b1;
        push_frame(8'h03, 4, 1'b0, 16, "busy_ign");
        push(4'b1001, "chain_gap_done");
        push_frame(8'h05, 3, 1'b0, 12, "chain");
        push(4'b1001, "chain_done");
        push_idle(1, "chain_idle");
        run(1); start = 1'b0; run(4);
        pattern = 8'hFF; start = 1'b1; run(1); start = 1'b0;
        run(10);
        run(1);
        pattern = 8'h05; len = 4'd3; start = 1'b1; run(1);
        start = 1'b0; run(13);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL leftover: %0d expected entries never compared, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx_moore.md
# serial_pattern_tx_moore

Moore-style serial pattern transmitter that produces a bit stream on `w` for the sequence detector. It latches a pattern of up to `WIDTH` bits and shifts it out MSB-first, holding each bit for `BIT_CLKS` clock cycles; the default pattern use is the 4-bit frame 0011. It sits upstream of the detector as on-board stimulus and self-test source, sharing its clock and reset.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LEN_W`, 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `BIT_CLKS`, 50000000: clock cycles per transmitted bit; must be ≥1. Benches override this to 4.
- `Clock` input, 1 bit: single clock; all state updates on the rising edge.
- `Resetn` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: frame request, sampled in IDLE only.
- `stop` input, 1 bit: abort request, sampled in SHIFT.
- `repeat_en` input, 1 bit: when 1 at frame end, the latched frame restarts immediately.
- `pattern` input, `WIDTH` bits: frame bits, transmitted `pattern[len-1]` down to `pattern[0]`.
- `len` input, `LEN_W` bits: frame length.
- `w` output, 1 bit: serial data; idle level is 1.
- `busy` output, 1 bit: 1 while in SHIFT.
- `bit_strobe` output, 1 bit: 1-cycle pulse in the first cycle of every bit.
- `done` output, 1 bit: 1-cycle pulse when a frame completes normally.

## Operation
- State machine with two states: IDLE and SHIFT. All outputs are registered.
- Reset (`Resetn`=0 at a rising edge), including mid-frame: state becomes IDLE and outputs become `w`=1, `busy`=0, `bit_strobe`=0, `done`=0. Bit counter and cycle counter clear. Latched pattern and length are don't-care.
- **IDLE**
  - `start`=1 with `len` in 1..WIDTH: latch `pattern` and `len`, then enter SHIFT.
  - `len`>WIDTH: the length is clamped to WIDTH.
  - `len`=0: `start` is ignored and the block stays in IDLE.
- **SHIFT**
  - Per-bit cycle counter runs 0..BIT_CLKS-1 (width $clog2(BIT_CLKS), minimum 1 bit). A bit index counts down from len-1 to 0.
  - `w` = latched bit at the current index. Later changes to `pattern`/`len` have no effect until the next start.
  - When the counter wraps and index>0: decrement the index and pulse `bit_strobe`.
  - When the counter wraps at index 0 (frame end): pulse `done`. Then:
    - `repeat_en`=1: reload index to len-1, stay in SHIFT and pulse `bit_strobe`.
    - Otherwise: go to IDLE with `w`=1.
- `stop`=1 in SHIFT aborts at the next edge: state becomes IDLE with `w`=1, `busy`=0, and no `done`. `stop` has priority over frame-end and repeat in the same cycle.
- `start` while in SHIFT is ignored. `stop` while in IDLE is ignored.
- With `Resetn`, `stop` and `start` all asserted in the same cycle, priority is reset > stop > start.

## Timing
- `start` sampled high at edge k (IDLE) gives, from cycle k+1:
  - `busy`=1, `bit_strobe`=1, `w`=first bit.
- Bit i (0-based, transmission order) occupies cycles k+1+i·BIT_CLKS through k+(i+1)·BIT_CLKS inclusive.
- Non-repeat frame end, at cycle k+1+len·BIT_CLKS:
  - `busy`=0, `w`=1, `done`=1 for exactly that one cycle.
  - Total `busy` time is len·BIT_CLKS cycles.
- Repeat frame end, at the same cycle:
  - `done`=1, `bit_strobe`=1, `busy` stays 1, and the first bit is re-driven with no gap.
- Earliest restart: a new `start` may be sampled in the same cycle `done` is high. The next frame then begins one cycle later, leaving exactly one idle (`w`=1) cycle between frames.
- BIT_CLKS=1: `bit_strobe` stays high for the whole frame and each bit lasts one cycle.
- Abort: `stop` sampled at edge m returns the block to IDLE outputs from cycle m+1.

## Test plan
- **Basic frame.** BIT_CLKS=4, `pattern`=8'h03, `len`=4, `start` pulse.
  - `w` = 0,0,1,1, each held 4 cycles; `bit_strobe` 4 times; `busy` high 16 cycles.
  - `done` pulses at cycle 17 with `w`=1.
  - Looped into the detector, its `z`=1 after the final bit.
- **Repeat mode.** `repeat_en`=1, `pattern`=8'h03, `len`=4.
  - Continuous 0011 with no gap; `done` pulses every 16 cycles; `busy` stays 1.
  - Deasserting `repeat_en` ends the stream after the current frame.
- **Abort.** `stop` asserted in the 2nd cycle of bit 2.
  - Next cycle: `w`=1, `busy`=0, no `done`.
  - `stop` and frame-end in the same cycle produce no `done`.
- **Length edges.**
  - `len`=0 with `start`: no activity.
  - `len`=15 with WIDTH=8: 8 bits sent (32 busy cycles).
  - `len`=1, `pattern`=8'h00: a single 0 bit for 4 cycles.
- **Reset mid-frame.** `Resetn`=0 for 1 cycle during bit 1.
  - Next cycle all outputs are at reset values.
  - A `start` held through reset is honoured only after `Resetn`=1.
- **Start ignored while busy.**
  - A second `start` with `pattern`=8'hFF during a frame leaves the stream unchanged.
  - `start` in the `done` cycle begins a new frame one cycle later.
